// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: hazard unit,
// EX branch resolution, ID jump detection, instruction memory and decode.
interface if_stage_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_taken;
  logic [31:0] jmp_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  // Environment side: drives control and memory data, observes fetch state
  modport master (
    output stall, br_taken, br_target, jmp_taken, jmp_target, imem_data,
    input  imem_addr, pc, ifid_pc4, ifid_instr, ifid_valid, fetch_count
  );

  // Fetch stage side
  modport slave (
    input  stall, br_taken, br_target, jmp_taken, jmp_target, imem_data,
    output imem_addr, pc, ifid_pc4, ifid_instr, ifid_valid, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC,
// addresses instruction memory, and loads the IF/ID register for decode.
// Redirects (EX branch, ID jump) squash the younger fetch into a bubble;
// there are no delay slots.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      reset,
  if_stage_if.slave bus
);

  logic [31:0] pc_q,          pc_d;
  logic [31:0] ifid_pc4_q,    ifid_pc4_d;
  logic [31:0] ifid_instr_q,  ifid_instr_d;
  logic        ifid_valid_q,  ifid_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state selection: branch beats stall beats jump beats sequential fetch
  always_comb begin
    pc_d          = pc_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    if (bus.br_taken) begin
      // The branch is older than anything stalled or any jump in ID
      pc_d         = {bus.br_target[31:2], 2'b00};
      ifid_pc4_d   = 32'h0000_0000;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (bus.stall) begin
      // Hold everything; decode will re-present any jump once the stall clears
      pc_d = pc_q;
    end else if (bus.jmp_taken) begin
      pc_d         = {bus.jmp_target[31:2], 2'b00};
      ifid_pc4_d   = 32'h0000_0000;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      pc_d          = pc_plus4;
      ifid_pc4_d    = pc_plus4;
      ifid_instr_d  = bus.imem_data;
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset that overrides any redirect or stall
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifid_pc4_q    <= 32'h0000_0000;
      ifid_instr_q  <= NOP_INSTR;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.ifid_pc4    = ifid_pc4_q;
  assign bus.ifid_instr  = ifid_instr_q;
  assign bus.ifid_valid  = ifid_valid_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: sequential fetch, stalls, branch and
// jump redirects, PC wraparound and mid-run reset.
module tb_if_stage;

  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Checks every observable field of the stage against expected values
  task automatic checkAll(input string tag, input logic [31:0] ePc,
                          input logic [31:0] ePc4, input logic [31:0] eInstr,
                          input logic eValid, input logic [31:0] eCount);
    checkOutput({tag, ".pc"},          bus.pc,                 ePc);
    checkOutput({tag, ".imem_addr"},   bus.imem_addr,          ePc);
    checkOutput({tag, ".ifid_pc4"},    bus.ifid_pc4,           ePc4);
    checkOutput({tag, ".ifid_instr"},  bus.ifid_instr,         eInstr);
    checkOutput({tag, ".ifid_valid"},  {31'd0, bus.ifid_valid}, {31'd0, eValid});
    checkOutput({tag, ".fetch_count"}, bus.fetch_count,        eCount);
  endtask

  // Drives one cycle of inputs, then waits past the rising edge to sample
  task automatic applyStimulus(input logic rst, input logic stl,
                               input logic brT, input logic [31:0] brA,
                               input logic jmT, input logic [31:0] jmA,
                               input logic [31:0] data);
    reset          = rst;
    bus.stall      = stl;
    bus.br_taken   = brT;
    bus.br_target  = brA;
    bus.jmp_taken  = jmT;
    bus.jmp_target = jmA;
    bus.imem_data  = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_target  = 32'h0;
    bus.jmp_taken  = 1'b0;
    bus.jmp_target = 32'h0;
    bus.imem_data  = 32'h0;

    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF);
    checkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    // Four sequential fetches
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2001_0001);
    checkAll("seq1", 32'h4, 32'h4, 32'h2001_0001, 1'b1, 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2002_0002);
    checkAll("seq2", 32'h8, 32'h8, 32'h2002_0002, 1'b1, 32'd2);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2003_0003);
    checkAll("seq3", 32'hC, 32'hC, 32'h2003_0003, 1'b1, 32'd3);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2004_0004);
    checkAll("seq4", 32'h10, 32'h10, 32'h2004_0004, 1'b1, 32'd4);

    // Three-cycle stall holds everything
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 32'h2005_0005);
      checkAll($sformatf("stall%0d", i), 32'h10, 32'h10, 32'h2004_0004, 1'b1, 32'd4);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2005_0005);
    checkAll("release", 32'h14, 32'h14, 32'h2005_0005, 1'b1, 32'd5);

    // Branch beats a concurrent stall and jump; target low bits dropped
    applyStimulus(0, 1, 1, 32'h0000_0103, 1, 32'h0000_0800, 32'h2005_0005);
    checkAll("brStall", 32'h100, 32'h0, 32'h0, 1'b0, 32'd5);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2006_0006);
    checkAll("afterBr", 32'h104, 32'h104, 32'h2006_0006, 1'b1, 32'd6);

    // Jump without stall redirects with a bubble
    applyStimulus(0, 0, 0, 32'h0, 1, 32'h0040_0000, 32'h2006_0006);
    checkAll("jmp", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd6);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2007_0007);
    checkAll("afterJmp", 32'h0040_0004, 32'h0040_0004, 32'h2007_0007, 1'b1, 32'd7);

    // Jump under stall is ignored
    applyStimulus(0, 1, 0, 32'h0, 1, 32'h0050_0000, 32'h2008_0008);
    checkAll("jmpStall", 32'h0040_0004, 32'h0040_0004, 32'h2007_0007, 1'b1, 32'd7);

    // Branch and jump together: branch wins, PC driven to top of address space
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0000_0800, 32'h2008_0008);
    checkAll("brJmp", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd7);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2008_0008);
    checkAll("wrap", 32'h0, 32'h0, 32'h2008_0008, 1'b1, 32'd8);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h2009_0009);
    checkAll("postWrap", 32'h4, 32'h4, 32'h2009_0009, 1'b1, 32'd9);

    // Reset coincident with a branch discards the branch
    applyStimulus(1, 0, 1, 32'h0000_0200, 0, 32'h0, 32'h200A_000A);
    checkAll("midReset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 32'h200A_000A);
    checkAll("postReset", 32'h4, 32'h4, 32'h200A_000A, 1'b1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
